gmii_fcs_check: RTL and testbench
=================================

// Module: gmii_fcs_check
// PURPOSE
//  In-line GMII receive frame checker on one rx clock domain. Sits between a port's
//  2-stage rx reg_slice and its pkt_fifo. Data passes unchanged with fixed latency.
//  A frame with a bad preamble/SFD, bad FCS, bad length or in_er set is marked by
//  out_er=1 on its last byte, so the downstream pkt_fifo discards it.
// PARAMETERS
//  MIN_LEN     64    minimum frame bytes after SFD, FCS included
//  MAX_LEN     1522  maximum frame bytes after SFD, FCS included (<=4094)
//  STAT_WIDTH  32    width of each statistics counter
// PORTS
//  clk          in   1   GMII rx clock (125 MHz)
//  rst          in   1   asynchronous, active-high reset
//  in_data      in   8   GMII rx data
//  in_dv        in   1   GMII rx data valid
//  in_er        in   1   GMII rx error
//  out_data     out  8   in_data delayed 2 cycles
//  out_dv       out  1   in_dv delayed 2 cycles; suppressed in SKIP
//  out_er       out  1   in_er delayed 2 cycles, OR frame-bad on the last byte
//  frame_done   out  1   1-cycle pulse, coincident with the last out byte of a frame
//  frame_ok     out  1   valid with frame_done: 1 = good frame
//  good_cnt     out  STAT_WIDTH  count of good frames
//  crc_err_cnt  out  STAT_WIDTH  count of frames with FCS mismatch
//  len_err_cnt  out  STAT_WIDTH  count of runt, oversize or preamble-error frames
// BEHAVIOUR
//  - Reset: all outputs 0, CRC=32'hFFFFFFFF, len=0, state=SKIP. Reset is async assert,
//    sync release.
//  - Pipeline: s1 <= in (data,dv,er); out <= s1. Latency is 2 cycles. There is no
//    backpressure.
//  - FSM:
//      SKIP: out_dv/out_er forced to 0. Go to IDLE when in_dv==0.
//      IDLE: on in_dv==1, go to PRE with bad=0. If the byte is not 8'h55, go to PRE
//            with pre_bad=1; if it is 8'hD5, go straight to DATA.
//      PRE:  8'h55 stays in PRE. 8'hD5 goes to DATA. Any other byte sets pre_bad
//            and stays in PRE.
//      DATA: each byte updates CRC-32 (reflected poly 32'hEDB88320, LSB first).
//            len increments and saturates at 4095.
//      in_dv==0 in PRE or DATA: end of frame, go to IDLE.
//  - End of frame is detected at cycle t with in_dv==0. At that point s1 holds the
//    last byte and the CRC covers all bytes. At edge t+1:
//      out_er = s1_er | bad
//      bad = (crc != 32'hDEBB20E3) | (len < MIN_LEN) | (len > MAX_LEN)
//            | pre_bad | er_seen | (state==PRE)
//      frame_done = 1, frame_ok = !bad.
//    CRC and len then reinitialise.
//  - er_seen: sticky flag, set by in_er during PRE or DATA, cleared at end of frame.
//  - in_er on any byte is forwarded on that byte in all states except SKIP.
//  - Back-to-back frames: a 1-cycle dv gap is sufficient. IDLE accepts in_dv==1 in
//    the cycle after end of frame.
//  - A frame that ends in PRE (no SFD) counts as a length error. CRC mismatch takes
//    priority over length error in counting. Exactly one counter increments per
//    frame_done.
//  - Reset mid-frame: outputs drop to 0 immediately. The remaining bytes are
//    suppressed (SKIP). No frame_done and no counter update occur for that frame.
// CONFIGURATION
//  GMII_FCS_STATS_EN defined: the three counters are live. They wrap modulo
//    2^STAT_WIDTH and clear only on rst.
//  GMII_FCS_STATS_EN undefined: no counter registers; good_cnt, crc_err_cnt and
//    len_err_cnt are tied to 0. All other behaviour is identical.
// TESTING
//  1 7x55+D5, 60B payload + correct FCS (64B) -> out identical, 2 cycles late;
//    out_er=0; frame_ok=1; good_cnt=1.
//  2 Same frame with payload byte 20 bit 0 flipped -> out_er=1 on last byte only;
//    frame_ok=0; crc_err_cnt=1.
//  3 60B frame with valid FCS, then 1523B frame with valid FCS -> both frame_ok=0;
//    len_err_cnt=2.
//  4 64B good frame with in_er=1 at byte 10 -> out_er=1 at byte 10 and last byte;
//    frame_ok=0.
//  5 rst pulse at byte 30 of a frame -> outputs 0, rest of the frame suppressed;
//    next good frame (1-cycle gap) has frame_ok=1; good_cnt=1.
//  6 Preamble 55 55 AA 55 D5 + good 64B frame -> frame_ok=0, len_err_cnt=1. Rerun
//    with GMII_FCS_STATS_EN undefined -> all counters stay 0.

Source files
------------

// File: rtl/gmii_fcs_check.sv
// gmii_fcs_check
// In-line GMII receive frame checker. Bytes pass through unchanged with a fixed
// 2-cycle latency. A frame with a bad preamble/SFD, bad FCS, bad length or any
// in_er is flagged by out_er on its last byte so that the downstream packet
// FIFO drops it. frame_done/frame_ok report the verdict on that same byte.
//
// Build option: define GMII_FCS_STATS_EN to enable the good / CRC-error /
// length-error frame counters. When it is undefined the counter outputs are
// tied to zero and no counter registers exist.
module gmii_fcs_check #(
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1522,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_dv,
  input  logic                  in_er,
  output logic [7:0]            out_data,
  output logic                  out_dv,
  output logic                  out_er,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [STAT_WIDTH-1:0] good_cnt,
  output logic [STAT_WIDTH-1:0] crc_err_cnt,
  output logic [STAT_WIDTH-1:0] len_err_cnt
);

  // Receive states. SKIP swallows the tail of a frame cut by reset.
  localparam logic [1:0] ST_SKIP = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PRE  = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  // Register value left after running data plus its own FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [11:0] LEN_SAT     = 12'd4095;
  localparam logic [11:0] MIN_LEN_L   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_L   = 12'(MAX_LEN);

  // One byte of reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[31:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [31:0] crc_r, crc_s;
  logic [11:0] len_r, len_s;
  logic        pre_bad_r, pre_bad_s;
  logic        er_seen_r, er_seen_s;
  logic        eof_s;
  logic        pre_end_s, crc_bad_s, len_bad_s, bad_s;
  logic [7:0]  s1_data_r;
  logic        s1_dv_r, s1_er_r;

  // Frame verdict, only meaningful in the cycle where eof_s is high.
  assign pre_end_s = (state_r == ST_PRE);
  assign crc_bad_s = (crc_r != CRC_RESIDUE);
  assign len_bad_s = (len_r < MIN_LEN_L) | (len_r > MAX_LEN_L);
  assign bad_s     = crc_bad_s | len_bad_s | pre_bad_r | er_seen_r | pre_end_s;

  // Next state, running CRC, length and sticky error flags for the frame in flight.
  always_comb begin
    state_s   = state_r;
    crc_s     = crc_r;
    len_s     = len_r;
    pre_bad_s = pre_bad_r;
    er_seen_s = er_seen_r;
    eof_s     = 1'b0;
    case (state_r)
      ST_SKIP: begin
        if (!in_dv) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SKIP;
        end
      end
      ST_IDLE: begin
        if (in_dv) begin
          crc_s     = CRC_INIT;
          len_s     = 12'd0;
          er_seen_s = 1'b0;
          if (in_data == SFD_BYTE) begin
            state_s   = ST_DATA;
            pre_bad_s = 1'b0;
          end else if (in_data == PRE_BYTE) begin
            state_s   = ST_PRE;
            pre_bad_s = 1'b0;
          end else begin
            state_s   = ST_PRE;
            pre_bad_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (in_dv) begin
          er_seen_s = er_seen_r | in_er;
          if (in_data == SFD_BYTE) begin
            state_s = ST_DATA;
          end else if (in_data == PRE_BYTE) begin
            state_s = ST_PRE;
          end else begin
            state_s   = ST_PRE;
            pre_bad_s = 1'b1;
          end
        end else begin
          eof_s     = 1'b1;
          state_s   = ST_IDLE;
          crc_s     = CRC_INIT;
          len_s     = 12'd0;
          pre_bad_s = 1'b0;
          er_seen_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (in_dv) begin
          er_seen_s = er_seen_r | in_er;
          crc_s     = crc32_byte(crc_r, in_data);
          if (len_r == LEN_SAT) begin
            len_s = len_r;
          end else begin
            len_s = len_r + 12'd1;
          end
        end else begin
          eof_s     = 1'b1;
          state_s   = ST_IDLE;
          crc_s     = CRC_INIT;
          len_s     = 12'd0;
          pre_bad_s = 1'b0;
          er_seen_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_SKIP;
      end
    endcase
  end

  // Frame-tracking state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_SKIP;
      crc_r     <= CRC_INIT;
      len_r     <= 12'd0;
      pre_bad_r <= 1'b0;
      er_seen_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      crc_r     <= crc_s;
      len_r     <= len_s;
      pre_bad_r <= pre_bad_s;
      er_seen_r <= er_seen_s;
    end
  end

  // Two-stage data pipeline; verdict merged into out_er on the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_r  <= 8'd0;
      s1_dv_r    <= 1'b0;
      s1_er_r    <= 1'b0;
      out_data   <= 8'd0;
      out_dv     <= 1'b0;
      out_er     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      s1_data_r  <= in_data;
      s1_dv_r    <= in_dv & (state_r != ST_SKIP);
      s1_er_r    <= in_er & (state_r != ST_SKIP);
      out_data   <= s1_data_r;
      out_dv     <= s1_dv_r;
      out_er     <= s1_er_r | (eof_s & bad_s);
      frame_done <= eof_s;
      frame_ok   <= eof_s & ~bad_s;
    end
  end

`ifdef GMII_FCS_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  // Frame statistics: exactly one counter moves per completed frame. A frame
  // that never saw an SFD is a length error; otherwise FCS mismatch wins over
  // length/preamble errors. A frame bad only because of in_er has corrupted
  // data and is counted with the CRC errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      len_err_cnt <= '0;
    end else if (eof_s) begin
      if (pre_end_s) begin
        len_err_cnt <= len_err_cnt + STAT_ONE;
      end else if (crc_bad_s) begin
        crc_err_cnt <= crc_err_cnt + STAT_ONE;
      end else if (len_bad_s | pre_bad_r) begin
        len_err_cnt <= len_err_cnt + STAT_ONE;
      end else if (er_seen_r) begin
        crc_err_cnt <= crc_err_cnt + STAT_ONE;
      end else begin
        good_cnt <= good_cnt + STAT_ONE;
      end
    end else begin
      good_cnt    <= good_cnt;
      crc_err_cnt <= crc_err_cnt;
      len_err_cnt <= len_err_cnt;
    end
  end
`else
  assign good_cnt    = '0;
  assign crc_err_cnt = '0;
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_gmii_fcs_check.sv
// Testbench for gmii_fcs_check: table of directed frames, a mid-frame reset
// sequence and random frames, all checked against a frame-level model.
module tb_gmii_fcs_check;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;
  localparam int SW      = 32;
  localparam int N       = 32768;
  localparam int C_GOOD  = 0;
  localparam int C_CRC   = 1;
  localparam int C_LEN   = 2;
`ifdef GMII_FCS_STATS_EN
  localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CNT_MASK = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_dv, in_er;
  logic [7:0]    out_data;
  logic          out_dv, out_er, frame_done, frame_ok;
  logic [SW-1:0] good_cnt, crc_err_cnt, len_err_cnt;

  gmii_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dv(in_dv), .in_er(in_er),
    .out_data(out_data), .out_dv(out_dv), .out_er(out_er),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .good_cnt(good_cnt), .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected output stream, indexed by the cycle the input byte was driven
  bit          exp_valid [N];
  logic [11:0] exp_val   [N];   // {data, dv, er, done, ok}

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_good = 0, m_crc = 0, m_len = 0;

  logic [7:0] fb[$];   // current frame bytes
  logic       fe[$];   // current frame in_er flags

  typedef struct {
    int pre_len; int bad_pre; bit no_sfd; int plen; int flip; int er;
    bit exp_ok; int exp_cls;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
  endtask

  // output stream checker, two cycles behind the driver
  always @(negedge clk) begin
    if (cyc >= 2 && exp_valid[cyc-2])
      check("stream", 32'({out_data, out_dv, out_er, frame_done, frame_ok}), 32'(exp_val[cyc-2]));
  end

  function automatic logic [31:0] crc_of(input int from, input int n);
    logic [31:0] c;
    logic [7:0]  d;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      d = fb[from+k];
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic set_exp_at(input int idx, input logic [7:0] d, input logic dv, input logic er,
                            input logic done, input logic ok);
    exp_valid[idx] = 1'b1;
    exp_val[idx]   = {d, dv, er, done, ok};
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clk); #1;
    in_data = d; in_dv = dv; in_er = er;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(8'h00, 1'b0, 1'b0);
      set_exp_at(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic build(input int pre_len, input int bad_pre, input bit no_sfd,
                       input int plen, input int flip, input int er);
    logic [31:0] r, fcs;
    int start;
    fb.delete(); fe.delete();
    start = 0;
    for (int k = 0; k < pre_len; k++) fb.push_back((k == bad_pre) ? 8'hAA : 8'h55);
    if (!no_sfd) begin
      fb.push_back(8'hD5);
      start = fb.size();
      for (int k = 0; k < plen; k++) begin r = $urandom; fb.push_back(r[7:0]); end
      fcs = crc_of(start, plen);
      fb.push_back(fcs[7:0]);   fb.push_back(fcs[15:8]);
      fb.push_back(fcs[23:16]); fb.push_back(fcs[31:24]);
      if (flip >= 0) fb[start+flip] = fb[start+flip] ^ 8'h01;
    end
    for (int k = 0; k < fb.size(); k++) fe.push_back(1'b0);
    if (!no_sfd && er >= 0) fe[start+er] = 1'b1;
  endtask

  // frame-level reference: find SFD, check preamble, FCS against the payload CRC, length
  task automatic classify(output logic bad, output int cls);
    int sfd, len, last;
    bit pb, er, crc_ok, lbad;
    logic [31:0] fcs;
    sfd = -1; pb = 1'b0; er = 1'b0; crc_ok = 1'b0;
    for (int k = 0; k < fb.size(); k++) if (sfd < 0 && fb[k] == 8'hD5) sfd = k;
    if (sfd < 0) begin
      cls = C_LEN;
    end else begin
      for (int k = 0; k < sfd; k++) if (fb[k] != 8'h55) pb = 1'b1;
      for (int k = 1; k < fe.size(); k++) if (fe[k]) er = 1'b1;
      len  = fb.size() - sfd - 1;
      last = fb.size() - 1;
      if (len >= 4) begin
        fcs = {fb[last], fb[last-1], fb[last-2], fb[last-3]};
        crc_ok = (crc_of(sfd + 1, len - 4) == fcs);
      end
      lbad = (len < MIN_LEN) || (len > MAX_LEN);
      if (!crc_ok) cls = C_CRC;
      else if (lbad || pb) cls = C_LEN;
      else if (er) cls = C_CRC;
      else cls = C_GOOD;
    end
    bad = (cls != C_GOOD);
  endtask

  task automatic send(input logic bad, input int gap);
    logic last;
    for (int k = 0; k < fb.size(); k++) begin
      last = (k == fb.size() - 1);
      drive(fb[k], 1'b1, fe[k]);
      set_exp_at(cyc, fb[k], 1'b1, fe[k] | (last & bad), last, last & ~bad);
    end
    idle(gap);
  endtask

  task automatic count(input int cls);
    if (cls == C_GOOD) m_good++;
    else if (cls == C_CRC) m_crc++;
    else m_len++;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".good_cnt"},    good_cnt,    32'(m_good) & CNT_MASK);
    check({tag, ".crc_err_cnt"}, crc_err_cnt, 32'(m_crc)  & CNT_MASK);
    check({tag, ".len_err_cnt"}, len_err_cnt, 32'(m_len)  & CNT_MASK);
  endtask

  initial begin
    logic bad;
    int   cls, p, sel, pl, bp, fl, er;

    //           pre bad_pre nosfd plen  flip  er  ok  class
    vecs[0]  = '{7, -1, 1'b0,   60,  -1,  -1, 1'b1, C_GOOD};  // 64B good
    vecs[1]  = '{7, -1, 1'b0,   60,  20,  -1, 1'b0, C_CRC};   // payload bit flip
    vecs[2]  = '{7, -1, 1'b0,   56,  -1,  -1, 1'b0, C_LEN};   // 60B runt
    vecs[3]  = '{7, -1, 1'b0, 1519,  -1,  -1, 1'b0, C_LEN};   // 1523B oversize
    vecs[4]  = '{7, -1, 1'b0,   60,  -1,  10, 1'b0, C_CRC};   // in_er at byte 10
    vecs[5]  = '{4,  2, 1'b0,   60,  -1,  -1, 1'b0, C_LEN};   // 55 55 AA 55 D5
    vecs[6]  = '{7, -1, 1'b0,   59,  -1,  -1, 1'b0, C_LEN};   // 63B
    vecs[7]  = '{7, -1, 1'b0, 1518,  -1,  -1, 1'b1, C_GOOD};  // 1522B
    vecs[8]  = '{7, -1, 1'b1,    0,  -1,  -1, 1'b0, C_LEN};   // no SFD
    vecs[9]  = '{0, -1, 1'b0,  100,  -1,  -1, 1'b1, C_GOOD};  // SFD straight from idle
    vecs[10] = '{3, -1, 1'b0,   61,  60,  -1, 1'b0, C_CRC};   // flip last payload byte

    rst = 1'b1; in_data = 8'h00; in_dv = 1'b0; in_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.out", 32'({out_data, out_dv, out_er, frame_done, frame_ok}), 32'd0);
    check_counters("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    set_exp_at(cyc, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // directed table, 1-cycle gap between frames except where counters are read
    for (int v = 0; v < 11; v++) begin
      build(vecs[v].pre_len, vecs[v].bad_pre, vecs[v].no_sfd, vecs[v].plen, vecs[v].flip, vecs[v].er);
      send(~vecs[v].exp_ok, (v % 2 == 0) ? 3 : 1);
      count(vecs[v].exp_cls);
      if (v % 2 == 0) check_counters($sformatf("vec%0d", v));
    end
    idle(3);
    check_counters("table");

    // reset at data byte 30 (frame index 38), then good frame after 1-cycle gap
    build(7, -1, 1'b0, 60, -1, -1);
    for (int k = 0; k < fb.size(); k++) begin
      drive(fb[k], 1'b1, fe[k]);
      if (k == 38) begin
        rst = 1'b1;
        set_exp_at(cyc,   8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        set_exp_at(cyc-1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        set_exp_at(cyc-2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        m_good = 0; m_crc = 0; m_len = 0;
        @(negedge clk);
        check_counters("rst_mid");
      end else if (k > 38) begin
        rst = 1'b0;
        set_exp_at(cyc, fb[k], 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        set_exp_at(cyc, fb[k], 1'b1, fe[k], 1'b0, 1'b0);
      end
    end
    idle(1);
    build(7, -1, 1'b0, 60, -1, -1);
    send(1'b0, 3);
    count(C_GOOD);
    check_counters("after_rst");

    // random frames checked against the frame-level model
    for (int r = 0; r < 30; r++) begin
      p   = $urandom_range(0, 7);
      pl  = $urandom_range(40, 110);
      sel = $urandom_range(0, 4);
      bp = -1; fl = -1; er = -1;
      if (sel == 1) fl = $urandom_range(0, pl - 1);
      else if (sel == 2) er = $urandom_range(0, pl + 3);
      else if (sel == 3 && p > 0) bp = $urandom_range(0, p - 1);
      build(p, bp, 1'b0, pl, fl, er);
      classify(bad, cls);
      send(bad, $urandom_range(1, 3));
      count(cls);
    end
    idle(3);
    check_counters("random");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
